// File: rtl/debug_reg_streamer_if.sv
// Purpose : beat-level valid/ready stream carrying (register index, value) pairs
//           from the debug register streamer to the host/UART link.
// Signals : valid - beat valid (master -> slave)
//           ready - slave accepts the beat (slave -> master)
//           index - register number of the beat
//           data  - captured register value
//           last  - final emitted beat of the current snapshot
interface debug_reg_streamer_if #(
  parameter int IdxW     = 3,
  parameter int RegWidth = 16
);
  logic                valid;
  logic                ready;
  logic [IdxW-1:0]     index;
  logic [RegWidth-1:0] data;
  logic                last;

  modport master (output valid, output index, output data, output last, input ready);
  modport slave  (input valid, input index, input data, input last, output ready);
endinterface

// File: rtl/debug_reg_streamer.sv
// Purpose : snapshots the core's packed register file on request and streams
//           it out one (index, value) beat per register slot, optionally
//           emitting only registers that changed since the previous snapshot.
// Ports   : i_clk          rising-edge clock
//           i_reset        synchronous active-high reset
//           i_debug_data   packed registers, reg i at [i*RegWidth +: RegWidth]
//           i_snap         capture request, honoured only in IDLE
//           i_changed_only sampled with an accepted snap
//           o_busy         high while streaming
//           o_done         one-cycle pulse in the first IDLE cycle after a stream
//           o_dropped      high while a snap is presented during a stream
//           o_drop_count   saturating count of dropped snaps
//           o_stream       beat output (master modport)
//
// state     | meaning
// ST_IDLE   | waiting for a snap request
// ST_STREAM | walking slots 0..NumRegs-1, one slot per cycle unless stalled
module debug_reg_streamer #(
  parameter int NumRegs  = 8,
  parameter int RegWidth = 16,
  parameter int IdxW     = $clog2(NumRegs)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NumRegs*RegWidth-1:0] i_debug_data,
  input  logic                        i_snap,
  input  logic                        i_changed_only,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_dropped,
  output logic [7:0]                  o_drop_count,
  debug_reg_streamer_if.master        o_stream
);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RegWidth-1:0] r_shadow [NumRegs];
  logic [RegWidth-1:0] r_prev   [NumRegs];
  logic [NumRegs-1:0]  r_sel;
  logic [IdxW-1:0]     r_idx;
  logic                r_done;
  logic [7:0]          r_drop_count;

  logic w_accept;
  logic w_advance;
  logic w_valid;
  logic w_drop;
  logic w_more_above;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_snap) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_valid   = r_sel[r_idx];
        // unselected slots burn exactly one cycle; selected ones wait for ready
        w_advance = !r_sel[r_idx] || o_stream.ready;
        if (w_advance && (r_idx == LastIdx)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_drop = i_snap && (r_state == ST_STREAM);

  // a beat is last when no later slot is still selected
  always_comb begin
    w_more_above = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if ((i > int'(r_idx)) && r_sel[i]) w_more_above = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_shadow[i] <= '0;
        r_prev[i]   <= '0;
      end
      r_sel        <= '0;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_done <= (r_state == ST_STREAM) && (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        for (int i = 0; i < NumRegs; i++) begin
          r_shadow[i] <= i_debug_data[i*RegWidth +: RegWidth];
          r_prev[i]   <= i_debug_data[i*RegWidth +: RegWidth];
          r_sel[i]    <= i_changed_only ?
                         (i_debug_data[i*RegWidth +: RegWidth] != r_prev[i]) : 1'b1;
        end
        r_idx <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + IdxW'(1);
      end
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign o_busy         = (r_state == ST_STREAM);
  assign o_done         = r_done;
  assign o_dropped      = w_drop;
  assign o_drop_count   = r_drop_count;
  assign o_stream.valid = w_valid;
  assign o_stream.index = r_idx;
  assign o_stream.data  = r_shadow[r_idx];
  assign o_stream.last  = w_valid && !w_more_above;

endmodule

// File: tb/tb_debug_reg_streamer.sv
module tb_debug_reg_streamer;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic         clk;
  logic         i_reset;
  logic [127:0] i_debug_data;
  logic         i_snap;
  logic         i_changed_only;
  logic         o_busy;
  logic         o_done;
  logic         o_dropped;
  logic [7:0]   o_drop_count;

  logic [15:0]  regs   [8];
  logic [15:0]  m_prev [8];
  beat_t        exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  debug_reg_streamer_if #(.IdxW(3), .RegWidth(16)) s_if ();

  debug_reg_streamer #(.NumRegs(8), .RegWidth(16), .IdxW(3)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_debug_data   (i_debug_data),
    .i_snap         (i_snap),
    .i_changed_only (i_changed_only),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_dropped      (o_dropped),
    .o_drop_count   (o_drop_count),
    .o_stream       (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    i_debug_data = '0;
    for (int i = 0; i < 8; i++) i_debug_data[i*16 +: 16] = regs[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected beats of one snapshot, pushed when the snap is issued
  task automatic push_expected(input logic co);
    int hi = -1;
    bit sel [8];
    for (int i = 0; i < 8; i++) begin
      sel[i] = co ? (regs[i] != m_prev[i]) : 1'b1;
      if (sel[i]) hi = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) exp_q.push_back('{idx: 3'(i), data: regs[i], last: (i == hi)});
      m_prev[i] = regs[i];
    end
  endtask

  // scoreboard monitor
  beat_t       mb;
  bit          prev_stall = 0;
  logic [2:0]  hold_idx;
  logic [15:0] hold_data;

  always @(negedge clk) begin
    if (!i_reset) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(s_if.valid), 32'd1);
        chk("hold_index", 32'(s_if.index), 32'(hold_idx));
        chk("hold_data",  32'(s_if.data),  32'(hold_data));
      end
      if (s_if.valid && s_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_index", 32'(s_if.index), 32'hFFFF_FFFF);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_index", 32'(s_if.index), 32'(mb.idx));
          chk("beat_data",  32'(s_if.data),  32'(mb.data));
          chk("beat_last",  32'(s_if.last),  32'(mb.last));
        end
      end
    end
    prev_stall = s_if.valid && !s_if.ready && !i_reset;
    hold_idx   = s_if.index;
    hold_data  = s_if.data;
  end

  // issue a snap and follow the stream until Done
  task automatic run_snap(input logic co, input int stall_idx, input int stall_n,
                          input int drop_at, input int drop_n, input int exp_busy,
                          input int exp_valid, input int exp_drops);
    int busy_n = 0;
    int valid_n = 0;
    int stall_left = stall_n;
    int cyc = 0;
    bit seen_done = 0;
    bit prev_busy = 0;
    push_expected(co);
    i_changed_only = co;
    i_snap = 1'b1;
    @(posedge clk); #1;
    i_snap = 1'b0;
    while (!seen_done && cyc < 400) begin
      i_snap = (cyc >= drop_at) && (cyc < drop_at + drop_n);
      if (s_if.valid && (int'(s_if.index) == stall_idx) && stall_left > 0) begin
        s_if.ready = 1'b0;
        stall_left--;
      end else begin
        s_if.ready = 1'b1;
      end
      @(negedge clk);
      if (o_busy) chk("dropped", 32'(o_dropped), 32'(i_snap));
      if (o_busy) busy_n++;
      if (s_if.valid) valid_n++;
      if (o_done) begin
        seen_done = 1;
        chk("done_after_busy", 32'({prev_busy, o_busy}), 32'b10);
      end
      prev_busy = o_busy;
      cyc++;
      @(posedge clk); #1;
    end
    i_snap = 1'b0;
    s_if.ready = 1'b1;
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("valid_cycles", 32'(valid_n), 32'(exp_valid));
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("drop_count", 32'(o_drop_count), 32'(exp_drops));
    chk("done_pulse_end", 32'({o_done, o_busy}), 32'd0);
  endtask

  initial begin
    int guard;
    i_reset = 1'b1;
    i_snap = 1'b0;
    i_changed_only = 1'b0;
    s_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      regs[i] = 16'(i + 1);
      m_prev[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({s_if.valid, o_busy, o_done, o_dropped, s_if.last}), 32'd0);
    chk("rst_drop_count", 32'(o_drop_count), 32'd0);
    chk("rst_index_data", 32'({s_if.index, s_if.data}), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // full snapshot, regs 1..8
    run_snap(1'b0, -1, 0, 1000, 0, 8, 8, 0);
    // idx2 stalled three cycles
    run_snap(1'b0, 2, 3, 1000, 0, 11, 11, 0);
    // only reg3 changes, to -5
    regs[3] = 16'hFFFB;
    run_snap(1'b1, -1, 0, 1000, 0, 8, 1, 0);
    // nothing changed
    run_snap(1'b1, -1, 0, 1000, 0, 8, 0, 0);
    // snap on the final stream cycle is dropped
    run_snap(1'b0, -1, 0, 7, 1, 8, 8, 1);
    // 300 more drops while idx0 is stalled, counter saturates
    run_snap(1'b0, 0, 300, 0, 300, 308, 308, 255);

    // reset while idx4 is valid
    push_expected(1'b0);
    i_changed_only = 1'b0;
    i_snap = 1'b1;
    @(posedge clk); #1;
    i_snap = 1'b0;
    guard = 0;
    while (!(s_if.valid && s_if.index == 3'd4) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_idx4", 32'(s_if.index), 32'd4);
    s_if.ready = 1'b0;
    i_reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl", 32'({s_if.valid, o_busy, o_done}), 32'd0);
    chk("abort_drop_count", 32'(o_drop_count), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_prev[i] = '0;
    i_reset = 1'b0;
    s_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'({s_if.valid, o_busy, o_done}), 32'd0);

    // change-only after reset: every non-zero register, last on idx6
    regs[0] = 16'h1111; regs[1] = 16'h2222; regs[2] = 16'h3333; regs[3] = 16'h8000;
    regs[4] = 16'h0042; regs[5] = 16'h0000; regs[6] = 16'h7FFF; regs[7] = 16'h0000;
    run_snap(1'b1, -1, 0, 1000, 0, 8, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
